// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave modport is the loader side and the master modport is the source/memory side.
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [7:0]            iByte;
  logic                  iByteValid;
  logic                  oByteReady;
  logic                  oWriteEnable;
  logic [ADDR_WIDTH-1:0] oWriteAddress;
  logic [27:0]           oWriteData;

  modport master (
    output iByte,
    output iByteValid,
    input  oByteReady,
    input  oWriteEnable,
    input  oWriteAddress,
    input  oWriteData
  );

  modport slave (
    input  iByte,
    input  iByteValid,
    output oByteReady,
    output oWriteEnable,
    output oWriteAddress,
    output oWriteData
  );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream loader for the mini CPU instruction memory.
// Defining LOADER_CHECKSUM_EN adds a trailing checksum byte and a CHECK state.
module program_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [7:0]  START_BYTE = 8'hA5
) (
  input  logic            Clock,
  input  logic            Reset,
  program_loader_if.slave bus,
  output logic            oCpuReset,
  output logic            oDone,
  output logic            oError
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_RUN,
    S_ERROR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHECK;
`else
  localparam state_t S_TAIL = S_RUN;
`endif

  localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

  state_t r_state;
  state_t w_next;

  logic                  r_ready;
  logic                  r_we;
  logic                  r_cpurst;
  logic                  r_done;
  logic                  r_err;
  logic [7:0]            r_len_lo;
  logic [15:0]           r_len;
  logic [15:0]           r_wcnt;
  logic [1:0]            r_idx;
  logic [23:0]           r_asm;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [27:0]           r_wdata;

  logic        w_acc;
  logic        w_start;
  logic        w_last;
  logic [15:0] w_len;

  assign w_acc   = bus.iByteValid && r_ready;
  assign w_start = w_acc && (bus.iByte == START_BYTE);
  assign w_len   = {bus.iByte, r_len_lo};
  assign w_last  = ({1'b0, r_wcnt} + 17'd1) == {1'b0, r_len};

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_ck;
  assign w_ck = bus.iByte + r_sum;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (w_start) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_acc) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_acc) begin
          if ({1'b0, w_len} > CAP) w_next = S_ERROR;
          else if (w_len == 16'd0) w_next = S_TAIL;
          else                     w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_acc && r_idx == 2'd3) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = w_last ? S_TAIL : S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_acc) w_next = (w_ck == 8'h00) ? S_RUN : S_ERROR;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Status and strobe flags are registered from the next state so they
  // line up with the state they describe, one edge after the trigger.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ready  <= 1'b0;
      r_we     <= 1'b0;
      r_cpurst <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_len_lo <= '0;
      r_len    <= '0;
      r_wcnt   <= '0;
      r_idx    <= '0;
      r_asm    <= '0;
      r_addr   <= '0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_ready  <= (w_next != S_WRITE);
      r_we     <= (w_next == S_WRITE);
      r_cpurst <= (w_next != S_RUN);
      r_done   <= (w_next == S_RUN);
      r_err    <= (w_next == S_ERROR);
      if (r_state == S_LEN_LO && w_acc) r_len_lo <= bus.iByte;
      if (r_state == S_LEN_HI && w_acc) begin
        r_len  <= w_len;
        r_wcnt <= '0;
        r_idx  <= '0;
        r_addr <= '0;
      end
      if (r_state == S_DATA && w_acc) begin
        r_idx <= r_idx + 2'd1;
        unique case (r_idx)
          2'd0: r_asm[7:0]   <= bus.iByte;
          2'd1: r_asm[15:8]  <= bus.iByte;
          2'd2: r_asm[23:16] <= bus.iByte;
          default: begin
            // Outputs only move on the edge into WRITE.
            r_wdata <= {bus.iByte[3:0], r_asm};
            r_waddr <= r_addr;
          end
        endcase
      end
      if (r_state == S_WRITE) begin
        r_addr <= r_addr + 1'b1;
        r_wcnt <= r_wcnt + 16'd1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge Clock) begin
    if (Reset)                        r_sum <= '0;
    else if (r_state == S_LEN_LO)     r_sum <= '0;
    else if (r_state == S_DATA && w_acc)
      r_sum <= r_sum + bus.iByte;
  end
`endif

  assign bus.oByteReady    = r_ready;
  assign bus.oWriteEnable  = r_we;
  assign bus.oWriteAddress = r_waddr;
  assign bus.oWriteData    = r_wdata;
  assign oCpuReset         = r_cpurst;
  assign oDone             = r_done;
  assign oError            = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write-port memory model.
// Frames gain a bench-computed checksum byte when LOADER_CHECKSUM_EN is set.
module tb_program_loader;
  localparam int AW = 10;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic oCpuReset;
  logic oDone;
  logic oError;

  program_loader_if #(.ADDR_WIDTH(AW)) bif();

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .bus       (bif.slave),
    .oCpuReset (oCpuReset),
    .oDone     (oDone),
    .oError    (oError)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_bad = 0;
  int n_wr = 0;
  int n_rdy_wr = 0;
  logic [AW-1:0] last_addr = '0;
  logic [27:0] mem [0:(1<<AW)-1];
  logic [7:0] q[$];
  logic [7:0] ck;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (bif.oWriteEnable) begin
      mem[bif.oWriteAddress] = bif.oWriteData;
      last_addr = bif.oWriteAddress;
      n_wr++;
      if (bif.oByteReady) n_rdy_wr++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge Clock);
    bif.iByte = b;
    bif.iByteValid = 1'b1;
    while (!bif.oByteReady && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge Clock);
    #1 bif.iByteValid = 1'b0;
  endtask

  task automatic send_q();
    foreach (q[i]) send_byte(q[i]);
    q.delete();
  endtask

  task automatic hdr(input logic [15:0] n);
    q.push_back(8'hA5);
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
  endtask

  task automatic word(input logic [31:0] w);
    q.push_back(w[7:0]);
    q.push_back(w[15:8]);
    q.push_back(w[23:16]);
    q.push_back(w[31:24]);
  endtask

  function automatic logic [7:0] cksum();
    logic [7:0] s = 8'h00;
    for (int i = 3; i < q.size(); i++) s += q[i];
    return 8'h00 - s;
  endfunction

  task automatic tail();
`ifdef LOADER_CHECKSUM_EN
    q.push_back(cksum());
`endif
  endtask

  task automatic wait_flag();
    int n = 0;
    while (!(oDone || oError) && n < 20) begin
      @(negedge Clock);
      n++;
    end
    #1;
  endtask

  initial begin
    bif.iByte = 8'h00;
    bif.iByteValid = 1'b0;
    repeat (4) @(negedge Clock);
    chk("rst_cpurst", oCpuReset, 1);
    chk("rst_rdy", bif.oByteReady, 0);
    chk("rst_we", bif.oWriteEnable, 0);
    chk("rst_done", oDone, 0);
    chk("rst_err", oError, 0);
    chk("rst_addr", bif.oWriteAddress, 0);
    chk("rst_data", bif.oWriteData, 0);
    Reset = 1'b0;
    @(negedge Clock);
    chk("rdy_rise", bif.oByteReady, 1);

    // basic two-word load with write-latency and done timing
    hdr(16'd2);
    word(32'h04332211);
    word(32'hF8776655);
    ck = cksum();
    send_q();
    @(negedge Clock);
    chk("w2_we", bif.oWriteEnable, 1);
    chk("w2_rdy", bif.oByteReady, 0);
    chk("w2_addr", bif.oWriteAddress, 1);
    chk("w2_data", bif.oWriteData, 28'h8776655);
    chk("w2_done", oDone, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(ck);
`endif
    @(negedge Clock);
    #1;
    chk("basic_done", oDone, 1);
    chk("basic_cpurst", oCpuReset, 0);
    chk("basic_nwr", n_wr, 2);
    chk("basic_m0", mem[0], 28'h4332211);
    chk("basic_m1", mem[1], 28'h8776655);

    // junk while running, then reload with N = 0
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    @(negedge Clock);
    chk("junk_done", oDone, 1);
    send_byte(8'hA5);
    @(negedge Clock);
    chk("reload_done", oDone, 0);
    chk("reload_cpurst", oCpuReset, 1);
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    @(negedge Clock);
    #1;
    chk("n0_done", oDone, 1);
    chk("n0_nwr", n_wr, 2);

    // length overflow: N = 1025
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h04);
    @(negedge Clock);
    #1;
    chk("ovf_err", oError, 1);
    chk("ovf_cpurst", oCpuReset, 1);
    chk("ovf_done", oDone, 0);
    chk("ovf_nwr", n_wr, 2);

    // full capacity: N = 1024
    hdr(16'd1024);
    for (int i = 0; i < 1024; i++) begin
      word({8'hF3, 8'h00, 16'(i)});
    end
    tail();
    send_q();
    wait_flag();
    chk("full_done", oDone, 1);
    chk("full_err", oError, 0);
    chk("full_nwr", n_wr, 1026);
    chk("full_last", last_addr, 1023);
    chk("full_m0", mem[0], 28'h3000000);
    chk("full_m512", mem[512], 28'h3000200);
    chk("full_m1023", mem[1023], 28'h30003FF);

    // reload after success restarts at address 0
    hdr(16'd1);
    word(32'hFFCAFE12);
    tail();
    send_q();
    wait_flag();
    chk("rl_done", oDone, 1);
    chk("rl_addr", last_addr, 0);
    chk("rl_m0", mem[0], 28'hFCAFE12);
    chk("rl_nwr", n_wr, 1027);

    // reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hDE);
    send_byte(8'hAD);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    chk("mid_cpurst", oCpuReset, 1);
    chk("mid_done", oDone, 0);
    chk("mid_err", oError, 0);
    chk("mid_rdy", bif.oByteReady, 0);
    chk("mid_we", bif.oWriteEnable, 0);
    chk("mid_addr", bif.oWriteAddress, 0);
    chk("mid_data", bif.oWriteData, 0);
    Reset = 1'b0;
    hdr(16'd1);
    word(32'hF2345678);
    tail();
    send_q();
    wait_flag();
    chk("post_done", oDone, 1);
    chk("post_m0", mem[0], 28'h2345678);
    chk("post_addr", last_addr, 0);
    chk("post_nwr", n_wr, 1028);

`ifdef LOADER_CHECKSUM_EN
    q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
    send_q();
    wait_flag();
    chk("ck_good_done", oDone, 1);
    chk("ck_good_err", oError, 0);
    q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF7};
    send_q();
    wait_flag();
    chk("ck_bad_err", oError, 1);
    chk("ck_bad_cpurst", oCpuReset, 1);
    chk("ck_bad_done", oDone, 0);
`endif

    chk("rdy_in_write", n_rdy_wr, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
